exe_sequencer: RTL

Parametrised instruction sequencer that supersedes the single-cycle opcode decoder of the matrix CPU. It fetches instruction words from instruction memory and decodes the opcode. It then issues a one-cycle enable pulse to exactly one matrix functional unit (add/sub, scale, mult, transpose), presents operand addresses, and waits for that unit's done handshake before advancing the PC. It sits between instruction memory and the functional units, and also provides stop handling, illegal-opcode and timeout error reporting, and a retired-instruction counter.

---
 rtl/exe_sequencer_if.sv | 56 +++++
 rtl/exe_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_sequencer_if.sv
// ---------------------------------------------------------------------------
// exe_sequencer_if
//
// Bundles every signal between the instruction sequencer and its surroundings
// (instruction memory and the four matrix functional units).
//
// Modports:
//   master : the sequencer itself
//            in : start, instr_data, instr_valid, unit_done
//            out: fetch_req, pc, unit_en, add_or_sub, read_from, write_to,
//                 dst, src1, src2, busy, halted, error, err_code, retired
//   slave  : the environment (memory, units, control); directions mirrored
//
// Instruction word layout, MSB to LSB:
//   opcode[OPC_W] | read_from | write_to | dst[ADDR_W] | src1[ADDR_W] | src2[ADDR_W]
// ---------------------------------------------------------------------------
interface exe_sequencer_if #(
    parameter int OPC_W  = 3,
    parameter int ADDR_W = 4,
    parameter int PC_W   = 8,
    parameter int CNT_W  = 16
);
    localparam int INSTR_W = OPC_W + 2 + 3 * ADDR_W;

    logic               start;
    logic [INSTR_W-1:0] instr_data;
    logic               instr_valid;
    logic               unit_done;

    logic               fetch_req;
    logic [PC_W-1:0]    pc;
    logic [3:0]         unit_en;
    logic               add_or_sub;
    logic               read_from;
    logic               write_to;
    logic [ADDR_W-1:0]  dst;
    logic [ADDR_W-1:0]  src1;
    logic [ADDR_W-1:0]  src2;
    logic               busy;
    logic               halted;
    logic               error;
    logic [1:0]         err_code;
    logic [CNT_W-1:0]   retired;

    modport master (
        input  start, instr_data, instr_valid, unit_done,
        output fetch_req, pc, unit_en, add_or_sub, read_from, write_to,
               dst, src1, src2, busy, halted, error, err_code, retired
    );

    modport slave (
        output start, instr_data, instr_valid, unit_done,
        input  fetch_req, pc, unit_en, add_or_sub, read_from, write_to,
               dst, src1, src2, busy, halted, error, err_code, retired
    );
endinterface

// File: rtl/exe_sequencer.sv
// ---------------------------------------------------------------------------
// exe_sequencer
//
// Instruction sequencer for the matrix CPU. Fetches one instruction word at a
// time, decodes its opcode, fires a single-cycle enable at the matching
// functional unit, then waits for that unit's done before moving the PC on.
// Stop (opcode 7) parks the sequencer in HALT; opcodes 5, 6 and anything above
// 7 park it in ERROR with err_code=1; a unit that never answers within
// TIMEOUT wait cycles parks it in ERROR with err_code=2.
//
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : exe_sequencer_if.master (see the interface file for the list)
//
// Every output is driven straight from a register.
// ---------------------------------------------------------------------------
module exe_sequencer #(
    parameter int OPC_W   = 3,
    parameter int ADDR_W  = 4,
    parameter int PC_W    = 8,
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic            clk,
    input  logic            reset,
    exe_sequencer_if.master bus
);
    localparam int INSTR_W = OPC_W + 2 + 3 * ADDR_W;
    localparam int WCNT_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_ISSUE,
        S_WAIT,
        S_HALT,
        S_ERROR
    } state_t;

    state_t              r_state;
    logic [INSTR_W-1:0]  r_ir;
    logic [WCNT_W-1:0]   r_waitCnt;
    logic [PC_W-1:0]     r_pc;
    logic [CNT_W-1:0]    r_retired;
    logic [3:0]          r_unitEn;
    logic                r_fetchReq;
    logic                r_busy;
    logic                r_halted;
    logic                r_error;
    logic [1:0]          r_errCode;
    logic                r_addOrSub;
    logic                r_readFrom;
    logic                r_writeTo;
    logic [ADDR_W-1:0]   r_dst;
    logic [ADDR_W-1:0]   r_src1;
    logic [ADDR_W-1:0]   r_src2;

    // Instruction register fields
    logic [OPC_W-1:0]    w_opcode;
    logic                w_readFrom;
    logic                w_writeTo;
    logic [ADDR_W-1:0]   w_dst;
    logic [ADDR_W-1:0]   w_src1;
    logic [ADDR_W-1:0]   w_src2;
    logic [3:0]          w_issueEn;
    logic                w_isStop;

    assign w_opcode   = r_ir[INSTR_W-1 -: OPC_W];
    assign w_readFrom = r_ir[3*ADDR_W+1];
    assign w_writeTo  = r_ir[3*ADDR_W];
    assign w_dst      = r_ir[3*ADDR_W-1 -: ADDR_W];
    assign w_src1     = r_ir[2*ADDR_W-1 -: ADDR_W];
    assign w_src2     = r_ir[ADDR_W-1:0];
    assign w_isStop   = (w_opcode == OPC_W'(7));

    // Opcode to unit mapping. A zero result means the opcode targets no unit,
    // i.e. it is either stop or illegal.
    always_comb begin
        w_issueEn = 4'b0000;
        case (w_opcode)
            OPC_W'(0), OPC_W'(1): w_issueEn = 4'b0001;
            OPC_W'(2):            w_issueEn = 4'b0010;
            OPC_W'(3):            w_issueEn = 4'b0100;
            OPC_W'(4):            w_issueEn = 4'b1000;
            default:              w_issueEn = 4'b0000;
        endcase
    end

    // Sequencer FSM with all outputs registered. unit_en defaults to zero every
    // cycle so the issue pulse can never be longer than one cycle; reset clears
    // it asynchronously so an in-flight pulse dies at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_ir       <= '0;
            r_waitCnt  <= '0;
            r_pc       <= '0;
            r_retired  <= '0;
            r_unitEn   <= 4'b0000;
            r_fetchReq <= 1'b0;
            r_busy     <= 1'b0;
            r_halted   <= 1'b0;
            r_error    <= 1'b0;
            r_errCode  <= 2'd0;
            r_addOrSub <= 1'b0;
            r_readFrom <= 1'b0;
            r_writeTo  <= 1'b0;
            r_dst      <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
        end else begin
            r_unitEn <= 4'b0000;
            case (r_state)
                S_IDLE, S_HALT, S_ERROR: begin
                    if (bus.start) begin
                        r_state    <= S_FETCH;
                        r_pc       <= '0;
                        r_retired  <= '0;
                        r_errCode  <= 2'd0;
                        r_fetchReq <= 1'b1;
                        r_busy     <= 1'b1;
                        r_halted   <= 1'b0;
                        r_error    <= 1'b0;
                    end
                end
                S_FETCH: begin
                    if (bus.instr_valid) begin
                        r_ir       <= bus.instr_data;
                        r_fetchReq <= 1'b0;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_readFrom <= w_readFrom;
                    r_writeTo  <= w_writeTo;
                    r_dst      <= w_dst;
                    r_src1     <= w_src1;
                    r_src2     <= w_src2;
                    // Only the add/sub unit cares about the direction bit
                    r_addOrSub <= (w_issueEn == 4'b0001) & w_opcode[0];
                    if (w_issueEn != 4'b0000) begin
                        r_unitEn <= w_issueEn;
                        r_state  <= S_ISSUE;
                    end else if (w_isStop) begin
                        r_busy   <= 1'b0;
                        r_halted <= 1'b1;
                        r_state  <= S_HALT;
                    end else begin
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                        r_errCode <= 2'd1;
                        r_state   <= S_ERROR;
                    end
                end
                S_ISSUE: begin
                    r_waitCnt <= '0;
                    r_state   <= S_WAIT;
                end
                S_WAIT: begin
                    // done is checked before the limit so a done arriving on
                    // the last allowed cycle still completes normally
                    if (bus.unit_done) begin
                        r_pc       <= r_pc + 1'b1;
                        if (r_retired != '1) begin
                            r_retired <= r_retired + 1'b1;
                        end
                        r_fetchReq <= 1'b1;
                        r_state    <= S_FETCH;
                    end else if (r_waitCnt == WCNT_W'(TIMEOUT - 1)) begin
                        r_busy    <= 1'b0;
                        r_error   <= 1'b1;
                        r_errCode <= 2'd2;
                        r_state   <= S_ERROR;
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.fetch_req  = r_fetchReq;
    assign bus.pc         = r_pc;
    assign bus.unit_en    = r_unitEn;
    assign bus.add_or_sub = r_addOrSub;
    assign bus.read_from  = r_readFrom;
    assign bus.write_to   = r_writeTo;
    assign bus.dst        = r_dst;
    assign bus.src1       = r_src1;
    assign bus.src2       = r_src2;
    assign bus.busy       = r_busy;
    assign bus.halted     = r_halted;
    assign bus.error      = r_error;
    assign bus.err_code   = r_errCode;
    assign bus.retired    = r_retired;
endmodule
